// File: rtl/vga_vram_scanout.sv
// 1bpp frame-buffer scanout: VRAM port B addressing, pixel select, sync delay.
// Define PIXEL_DOUBLE_EN for 320x240 mode (each VRAM pixel drawn as 2x2).
module vga_vram_scanout #(
   parameter int         H_ACTIVE       = 640,
   parameter int         V_ACTIVE       = 480,
   parameter int         BYTES_PER_LINE = 80,
   parameter int         RD_LAT         = 1,
   parameter logic [7:0] FG_COLOR       = 8'hFF,
   parameter logic [7:0] BG_COLOR       = 8'h00
) (
   input  logic        clk,
   input  logic        clr,
   input  logic [9:0]  x,
   input  logic [9:0]  y,
   input  logic        vidon_in,
   input  logic        hsync_in,
   input  logic        vsync_in,
   output logic [15:0] vram_addr,
   input  logic [7:0]  vram_data,
   output logic [2:0]  red,
   output logic [2:0]  green,
   output logic [1:0]  blue,
   output logic        hsync,
   output logic        vsync
);

   localparam int         L     = RD_LAT + 2;
   localparam logic [9:0] H_MAX = 10'(H_ACTIVE);
   localparam logic [9:0] V_MAX = 10'(V_ACTIVE);

`ifdef PIXEL_DOUBLE_EN
   localparam logic [15:0] STEP = 16'(BYTES_PER_LINE / 2);
`else
   localparam logic [15:0] STEP = 16'(BYTES_PER_LINE);
`endif

   logic [15:0]   line_base;
   logic [15:0]   line_base_next;
   logic [9:0]    y_prev;
   logic [15:0]   col_off;
   logic [2:0]    x_sel;
   logic          y_step;

   logic [L-1:0]      hs_d;
   logic [L-1:0]      vs_d;
   logic [RD_LAT:0]   vid_d;
   logic [2:0]        xs_d [RD_LAT+1];
   logic              pix_bit;
   logic [7:0]        color;

`ifdef PIXEL_DOUBLE_EN
   assign col_off = 16'(x[9:4]);
   assign x_sel   = x[3:1];
   // two display lines share one VRAM line; advance on entering an even row
   assign y_step  = (y != y_prev) && (y < V_MAX) && !y[0];
`else
   assign col_off = 16'(x[9:3]);
   assign x_sel   = x[2:0];
   assign y_step  = (y != y_prev) && (y < V_MAX);
`endif

   always_comb begin
      line_base_next = line_base;
      if (y == 10'd0)
         line_base_next = '0;
      else if (y_step)
         line_base_next = line_base + STEP;
   end

   always_ff @(posedge clk) begin
      if (clr) begin
         line_base <= '0;
         y_prev    <= '0;
         vram_addr <= '0;
      end else begin
         line_base <= line_base_next;
         y_prev    <= y;
         if (x < H_MAX && y < V_MAX)
            vram_addr <= line_base_next + col_off;
      end
   end

   // stage RD_LAT of the delay lines lines up with the RAM output
   assign pix_bit = vram_data[xs_d[RD_LAT]];
   assign color   = !vid_d[RD_LAT] ? 8'h00
                  : pix_bit        ? FG_COLOR : BG_COLOR;

   always_ff @(posedge clk) begin
      if (clr) begin
         hs_d  <= '1;
         vs_d  <= '1;
         vid_d <= '0;
         for (int i = 0; i <= RD_LAT; i++)
            xs_d[i] <= '0;
         {red, green, blue} <= 8'h00;
      end else begin
         hs_d  <= {hs_d[L-2:0], hsync_in};
         vs_d  <= {vs_d[L-2:0], vsync_in};
         vid_d <= {vid_d[RD_LAT-1:0], vidon_in};
         xs_d[0] <= x_sel;
         for (int i = 1; i <= RD_LAT; i++)
            xs_d[i] <= xs_d[i-1];
         {red, green, blue} <= color;
      end
   end

   assign hsync = hs_d[L-1];
   assign vsync = vs_d[L-1];

endmodule

// File: doc/vga_vram_scanout.md
Name: vga_vram_scanout

Overview:
- Display-side reader of the 1bpp frame buffer. The CPU/BUS writes VRAM port A; this block drives VRAM port B address and turns returned bytes into pixels for the VGA pins.
- Sits between the 640x480 timing generator and the top-level red/green/blue/hsync/vsync outputs.
- Delays sync and blanking so they stay aligned with the pixel data.
- Port B of VRAM is clocked by the same 25 MHz pixel clock as this block.

Parameters:
- H_ACTIVE, 640, active pixels per line.
- V_ACTIVE, 480, active lines per frame.
- BYTES_PER_LINE, 80, VRAM bytes per active line (H_ACTIVE/8).
- RD_LAT, 1, VRAM port B read latency in clocks (1..2).
- FG_COLOR, 8'hFF, RGB332 colour for a set bit.
- BG_COLOR, 8'h00, RGB332 colour for a clear bit.

Ports:
- clk  in  1  pixel clock (25 MHz).
- clr  in  1  synchronous active-high reset.
- x  in  10  current pixel column from the timing generator.
- y  in  10  current pixel row from the timing generator.
- vidon_in  in  1  active-video flag from the timing generator.
- hsync_in  in  1  horizontal sync from the timing generator.
- vsync_in  in  1  vertical sync from the timing generator.
- vram_addr  out  16  VRAM port B address (registered).
- vram_data  in  8  VRAM port B read data.
- red  out  3  pixel red.
- green  out  3  pixel green.
- blue  out  2  pixel blue.
- hsync  out  1  delayed horizontal sync.
- vsync  out  1  delayed vertical sync.

Behaviour:
- Reset: one clock and one reset, named clk and clr. clr is synchronous and active-high.
  - While clr is high at a rising edge: vram_addr=0, red/green/blue=0, hsync=1, vsync=1 (idle level), line_base=0, all delay-line stages cleared to blank with sync at 1.
  - Applying clr mid-line blanks the output for the full pipeline depth after release.
- Line base: register line_base, 16 bits, tracks y*BYTES_PER_LINE without a multiplier.
  - y==0: line_base=0.
  - y changes and y<V_ACTIVE: line_base += BYTES_PER_LINE.
  - y>=V_ACTIVE: line_base holds.
  - y_prev is a register compared against y each clock.
- Address: vram_addr <= line_base_next + x[9:3] every clock (line_base_next is the value being loaded this cycle).
  - x>=H_ACTIVE or y>=V_ACTIVE: vram_addr holds its previous value.
  - The maximum address is 38399, so there is no wrap.
- Pipeline: total latency L = RD_LAT + 2 clocks from x/y/vidon_in/hsync_in/vsync_in to red/green/blue/hsync/vsync.
  - Stage 1 registers the address.
  - RD_LAT stages cover the RAM.
  - The final stage registers the colour.
  - hsync_in, vsync_in, vidon_in and x[2:0] pass through an L-deep shift register.
- Pixel select: bit = vram_data[x_d[2:0]], where x_d[2:0] is the delayed value. Bit 0 is the leftmost pixel of each byte.
  - Delayed vidon=1: {red,green,blue} = bit ? FG_COLOR : BG_COLOR.
  - Delayed vidon=0: all zero.
- Boundaries:
  - A y change and y==0 in the same clock: reset wins, line_base=0.
  - Garbage x/y from the timing generator during blanking never affects visible pixels, because the delayed vidon gates the output.

Optional Feature:
- Macro PIXEL_DOUBLE_EN.
- Defined: 320x240 mode.
  - Address = line_base + x[9:4], with line_base stepping by 40 only on even y transitions (y[0]==0 after the change).
  - Pixel select uses vram_data[x_d[3:1]].
  - Frame buffer is 9600 bytes, max address 9599.
- Undefined: native 640x480 mapping as above. No extra logic is synthesised.

Test Plan:
- Reset: hold clr 3 clocks with random inputs -> vram_addr=0, RGB=0, hsync=vsync=1. After release, first non-zero RGB appears no earlier than L clocks after vidon_in rises.
- Address mapping: y=0,x=0 -> vram_addr=0. y=1,x=8 -> 81. y=479,x=639 -> 38399. y=480 -> addr holds 38399.
- Pixel order: RAM model returns 8'h01 at addr 0, x sweeps 0..7 on line 0 -> only pixel x=0 is FF, pixels 1..7 are 00, each L clocks after its input.
- Sync alignment: hsync_in low for 96 clocks -> hsync low for exactly 96 clocks, delayed by L (3 when RD_LAT=1, 4 when RD_LAT=2).
- Blanking: vram_data forced 8'hFF with vidon_in=0 -> RGB=0 throughout. vidon_in=1 -> RGB=FF after L clocks.
- PIXEL_DOUBLE_EN: y=2,x=16 -> addr 41. y=3,x=16 -> addr 41. Data 8'h02 -> pixels x=2,3 of each 16-pixel group are FG.
